// File: rtl/sync_pkg.sv
// Shared limits and helpers for the sync_bus_filter synchronizer family.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 8;
  localparam int SYNC_MAX_FILTER = 255;

  // Width of a counter that must hold values 0..filter_len; never narrower than 1 bit.
  function automatic int sync_cnt_width(input int filter_len);
    int w;
    w = 1;
    while ((1 << w) < (filter_len + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_filter_lane.sv
// One bit lane: optional stability filter on the synced bit, plus rise/fall pulses
// when SYNC_EDGE_EN is defined (otherwise rise/fall are constant 0).
module sync_filter_lane
  import sync_pkg::*;
#(
  parameter int   FILTER_LEN = 0,
  parameter logic RESET_BIT  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = sync_cnt_width(FILTER_LEN);

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign d_out = sync_in;
      assign busy  = 1'b0;
    end else begin : g_filter
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             d_out_reg;
      logic             d_out_next;

      // A candidate value must persist FILTER_LEN edges; any reversion restarts the count.
      always_comb begin
        cnt_next   = cnt_reg;
        d_out_next = d_out_reg;
        if (sync_in == d_out_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          d_out_next = sync_in;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          d_out_reg <= RESET_BIT;
        end else begin
          cnt_reg   <= cnt_next;
          d_out_reg <= d_out_next;
        end
      end

      assign d_out = d_out_reg;
      assign busy  = |cnt_reg;
    end
  endgenerate

`ifdef SYNC_EDGE_EN
  logic d_out_q_reg;
  logic rise_reg;
  logic fall_reg;

  // d_out_q starts at the reset value so reset itself never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q_reg <= RESET_BIT;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
    end else begin
      d_out_q_reg <= d_out;
      rise_reg    <= ~d_out_q_reg & d_out;
      fall_reg    <= d_out_q_reg & ~d_out;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_bus_filter.sv
// Multi-bit, multi-stage synchronizer with optional per-bit stability filter.
// Define SYNC_EDGE_EN to enable the registered rise/fall pulse outputs.
module sync_bus_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 7,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
);

  generate
    if ((STAGES < SYNC_MIN_STAGES) || (STAGES > SYNC_MAX_STAGES)) begin : g_bad_stages
      $error("sync_bus_filter: STAGES=%0d outside %0d..%0d", STAGES, SYNC_MIN_STAGES,
             SYNC_MAX_STAGES);
    end
    if ((FILTER_LEN < 0) || (FILTER_LEN > SYNC_MAX_FILTER)) begin : g_bad_filter
      $error("sync_bus_filter: FILTER_LEN=%0d outside 0..%0d", FILTER_LEN, SYNC_MAX_FILTER);
    end
  endgenerate

  logic [WIDTH-1:0] s_reg [STAGES];
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        s_reg[k] <= RESET_VAL;
      end
    end else begin
      s_reg[0] <= d_in;
      for (int k = 1; k < STAGES; k++) begin
        s_reg[k] <= s_reg[k-1];
      end
    end
  end

  assign sync = s_reg[STAGES-1];

  // Lanes are independent: no attempt is made to keep the bus coherent.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      sync_filter_lane #(
        .FILTER_LEN (FILTER_LEN),
        .RESET_BIT  (RESET_VAL[gi])
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .sync_in (sync[gi]),
        .d_out   (d_out[gi]),
        .rise    (rise[gi]),
        .fall    (fall[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sync_bus_filter.sv
// Scoreboard bench for sync_bus_filter: four parameterisations driven side by side.
module tb_sync_bus_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SYNC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic [6:0] din  [4];
  logic       rst  [4];
  logic [6:0] dout [4];
  logic [6:0] busy [4];
  logic [6:0] rise [4];
  logic [6:0] fall [4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: defaults, 1: STAGES=4, 2: FILTER_LEN=3, 3: FILTER_LEN=3 with RESET_VAL=7F
  sync_bus_filter u_a (
    .clk(clk), .reset(rst[0]), .d_in(din[0]), .d_out(dout[0]),
    .rise(rise[0]), .fall(fall[0]), .busy(busy[0]));
  sync_bus_filter #(.STAGES(4)) u_b (
    .clk(clk), .reset(rst[1]), .d_in(din[1]), .d_out(dout[1]),
    .rise(rise[1]), .fall(fall[1]), .busy(busy[1]));
  sync_bus_filter #(.FILTER_LEN(3)) u_c (
    .clk(clk), .reset(rst[2]), .d_in(din[2]), .d_out(dout[2]),
    .rise(rise[2]), .fall(fall[2]), .busy(busy[2]));
  sync_bus_filter #(.FILTER_LEN(3), .RESET_VAL(7'h7F)) u_d (
    .clk(clk), .reset(rst[3]), .d_in(din[3]), .d_out(dout[3]),
    .rise(rise[3]), .fall(fall[3]), .busy(busy[3]));

  typedef struct {
    int         cyc;
    int         dut;
    logic [6:0] d_out;
    logic [6:0] busy;
    logic [6:0] rise;
    logic [6:0] fall;
    string      name;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [6:0] e(input logic [6:0] v);
    return EDGE ? v : 7'h00;
  endfunction

  task automatic push(input int c, input int d, input logic [6:0] o, input logic [6:0] b,
                      input logic [6:0] r, input logic [6:0] f, input string nm);
    exp_t x;
    x.cyc = c; x.dut = d; x.d_out = o; x.busy = b; x.rise = r; x.fall = f; x.name = nm;
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are observed every negedge; due expectations are popped and compared.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      n_checks++;
      if (x.cyc != cyc || dout[x.dut] !== x.d_out || busy[x.dut] !== x.busy ||
          rise[x.dut] !== x.rise || fall[x.dut] !== x.fall) begin
        $display("FAIL %s cyc=%0d dut=%0d: got d_out=%h busy=%h rise=%h fall=%h, want d_out=%h busy=%h rise=%h fall=%h (due cyc %0d)",
                 x.name, cyc, x.dut, dout[x.dut], busy[x.dut], rise[x.dut], fall[x.dut],
                 x.d_out, x.busy, x.rise, x.fall, x.cyc);
      end else begin
        n_pass++;
        $display("ok   %s cyc=%0d dut=%0d d_out=%h busy=%h rise=%h fall=%h",
                 x.name, cyc, x.dut, dout[x.dut], busy[x.dut], rise[x.dut], fall[x.dut]);
      end
    end
  end

  initial begin
    int c;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      din[k] = 7'h00;
    end
    din[3] = 7'h7F;

    tick(2);
    c = cyc;
    push(c, 0, 7'h00, 7'h00, 7'h00, 7'h00, "rst_a");
    push(c, 1, 7'h00, 7'h00, 7'h00, 7'h00, "rst_b");
    push(c, 2, 7'h00, 7'h00, 7'h00, 7'h00, "rst_c");
    push(c, 3, 7'h7F, 7'h00, 7'h00, 7'h00, "rst_d");
    tick(1);

    // Release: D holds 7F, so no pulse may appear.
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    c = cyc;
    for (int k = 1; k <= 3; k++) push(c + k, 3, 7'h7F, 7'h00, 7'h00, 7'h00, "d_release");
    tick(4);

    // Defaults: 2-edge latency, all lanes at once, no busy.
    c = cyc;
    din[0] = 7'h55;
    push(c + 1, 0, 7'h00, 7'h00, 7'h00,    7'h00, "a_lat1");
    push(c + 2, 0, 7'h55, 7'h00, 7'h00,    7'h00, "a_lat2");
    push(c + 3, 0, 7'h55, 7'h00, e(7'h55), 7'h00, "a_rise");
    push(c + 4, 0, 7'h55, 7'h00, 7'h00,    7'h00, "a_rise_end");
    tick(5);

    // STAGES=4: bit 0 follows after exactly 4 edges, both directions.
    c = cyc;
    din[1] = 7'h01;
    push(c + 3, 1, 7'h00, 7'h00, 7'h00,    7'h00, "b_up_lat3");
    push(c + 4, 1, 7'h01, 7'h00, 7'h00,    7'h00, "b_up_lat4");
    push(c + 5, 1, 7'h01, 7'h00, e(7'h01), 7'h00, "b_rise");
    tick(5);
    c = cyc;
    din[1] = 7'h00;
    push(c + 3, 1, 7'h01, 7'h00, 7'h00, 7'h00,    "b_dn_lat3");
    push(c + 4, 1, 7'h00, 7'h00, 7'h00, 7'h00,    "b_dn_lat4");
    push(c + 5, 1, 7'h00, 7'h00, 7'h00, e(7'h01), "b_fall");
    tick(6);

    // FILTER_LEN=3: 2-cycle glitch is rejected.
    c = cyc;
    din[2] = 7'h04;
    push(c + 2, 2, 7'h00, 7'h00, 7'h00, 7'h00, "c_glitch_idle");
    push(c + 3, 2, 7'h00, 7'h04, 7'h00, 7'h00, "c_glitch_busy1");
    push(c + 4, 2, 7'h00, 7'h04, 7'h00, 7'h00, "c_glitch_busy2");
    push(c + 5, 2, 7'h00, 7'h00, 7'h00, 7'h00, "c_glitch_clear");
    push(c + 6, 2, 7'h00, 7'h00, 7'h00, 7'h00, "c_glitch_hold");
    tick(2);
    din[2] = 7'h00;
    tick(6);

    // FILTER_LEN=3: held change lands after STAGES+3 edges.
    c = cyc;
    din[2] = 7'h04;
    push(c + 2, 2, 7'h00, 7'h00, 7'h00,    7'h00, "c_hold_idle");
    push(c + 3, 2, 7'h00, 7'h04, 7'h00,    7'h00, "c_hold_busy1");
    push(c + 4, 2, 7'h00, 7'h04, 7'h00,    7'h00, "c_hold_busy2");
    push(c + 5, 2, 7'h04, 7'h00, 7'h00,    7'h00, "c_hold_land");
    push(c + 6, 2, 7'h04, 7'h00, e(7'h04), 7'h00, "c_hold_rise");
    tick(7);
    din[2] = 7'h00;
    tick(7);

    // Reset mid-count discards the pending change; a full count follows release.
    c = cyc;
    din[2] = 7'h04;
    push(c + 4,  2, 7'h00, 7'h04, 7'h00,    7'h00, "c_pre_rst_busy");
    push(c + 5,  2, 7'h00, 7'h00, 7'h00,    7'h00, "c_in_rst");
    push(c + 6,  2, 7'h00, 7'h00, 7'h00,    7'h00, "c_post_rst1");
    push(c + 8,  2, 7'h00, 7'h04, 7'h00,    7'h00, "c_recount1");
    push(c + 9,  2, 7'h00, 7'h04, 7'h00,    7'h00, "c_recount2");
    push(c + 10, 2, 7'h04, 7'h00, 7'h00,    7'h00, "c_recount_land");
    push(c + 11, 2, 7'h04, 7'h00, e(7'h04), 7'h00, "c_recount_rise");
    tick(4);
    rst[2] = 1'b1;
    tick(1);
    rst[2] = 1'b0;
    tick(7);

    // RESET_VAL=7F: bit 6 dropping yields one fall pulse, never a rise.
    c = cyc;
    din[3] = 7'h3F;
    push(c + 4, 3, 7'h7F, 7'h40, 7'h00, 7'h00,    "d_busy");
    push(c + 5, 3, 7'h3F, 7'h00, 7'h00, 7'h00,    "d_drop");
    push(c + 6, 3, 7'h3F, 7'h00, 7'h00, e(7'h40), "d_fall");
    push(c + 7, 3, 7'h3F, 7'h00, 7'h00, 7'h00,    "d_fall_end");
    tick(8);

    for (int k = 0; k < 5 && q.size() > 0; k++) tick(1);
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      n_checks += q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
